// File: rtl/psr_pkg.sv
// psr_pkg: shared definitions for the program status register unit.
//   - mode encodings and mode-validity helpers
//   - CPSR bit positions and the mask of implemented PSR bits
//   - condition-code enum
//   - SPSR reset constant and a masked MSR merge helper
// Optional feature macro: PSR_FIQ_EN (makes FIQ mode 10001 valid and
// gives it an SPSR bank). When it is undefined, 10001 is an invalid mode.
package psr_pkg;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    localparam int CPSR_N = 31;
    localparam int CPSR_Z = 30;
    localparam int CPSR_C = 29;
    localparam int CPSR_V = 28;
    localparam int CPSR_I = 7;
    localparam int CPSR_F = 6;
    localparam int CPSR_T = 5;

    // Only NZCV and I/F/T/M are implemented; everything else reads 0.
    localparam logic [31:0] PSR_MASK   = 32'hF000_00FF;
    localparam logic [31:0] SPSR_RESET = 32'h0000_0010;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    function automatic logic mode_valid(input logic [4:0] m);
        logic ok;
        case (m)
            MODE_USR, MODE_IRQ, MODE_SVC,
            MODE_ABT, MODE_UND, MODE_SYS: ok = 1'b1;
`ifdef PSR_FIQ_EN
            MODE_FIQ:                     ok = 1'b1;
`endif
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Valid exception modes, i.e. those that own an SPSR bank.
    function automatic logic mode_has_spsr(input logic [4:0] m);
        return mode_valid(m) && (m != MODE_USR) && (m != MODE_SYS);
    endfunction

    // MSR field merge: mask = {f,s,x,c}. The s and x fields hold no
    // implemented bits, so only f and c matter.
    function automatic logic [31:0] psr_merge(input logic [31:0] old_val,
                                              input logic [31:0] data,
                                              input logic [3:0]  mask);
        logic [31:0] r;
        r = old_val;
        if (mask[3]) r[31:24] = data[31:24];
        if (mask[0]) r[7:0]   = data[7:0];
        return r & PSR_MASK;
    endfunction

endpackage

// File: rtl/psr_unit_cond_check.sv
// cond_check: combinational ARM condition-code evaluation.
// Ports:
//   cond       in  4  condition field
//   n,z,c,v    in  1  stored flags
//   cond_pass  out 1  condition true
module cond_check
    import psr_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       n,
    input  logic       z,
    input  logic       c,
    input  logic       v,
    output logic       cond_pass
);

    always_comb begin
        cond_pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c && !z;
            COND_LS: cond_pass = !c || z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z && (n == v);
            COND_LE: cond_pass = z || (n != v);
            COND_AL: cond_pass = 1'b1;
            COND_NV: cond_pass = 1'b0;
            default: cond_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/psr_unit.sv
// psr_unit: CPSR plus banked SPSRs for the ARM7TDMI execute stage.
// Handles ALU flag writes, MSR/BX writes, exception entry/return and
// condition-code evaluation for the next instruction.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   flag_we, in_n/z/c/v              ALU flag write
//   msr_we, msr_spsr, msr_mask,
//   msr_data                         MSR write (mask = {f,s,x,c})
//   bx_we, bx_t                      BX T-bit write
//   exc_req, exc_mode, exc_fmask     exception entry
//   exc_ret                          restore CPSR from current SPSR
//   cond / cond_pass                 condition check on stored flags
//   cpsr, spsr, n/z/c/v, mode, priv  status outputs
//   psr_err                          one-cycle pulse after an illegal request
// Optional feature macro: PSR_FIQ_EN (FIQ mode and SPSR_fiq).
module psr_unit
    import psr_pkg::*;
#(
    parameter logic [31:0] RESET_CPSR = 32'h0000_00D3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flag_we,
    input  logic        in_n,
    input  logic        in_z,
    input  logic        in_c,
    input  logic        in_v,
    input  logic        msr_we,
    input  logic        msr_spsr,
    input  logic [3:0]  msr_mask,
    input  logic [31:0] msr_data,
    input  logic        bx_we,
    input  logic        bx_t,
    input  logic        exc_req,
    input  logic [4:0]  exc_mode,
    input  logic        exc_fmask,
    input  logic        exc_ret,
    input  logic [3:0]  cond,
    output logic        cond_pass,
    output logic [31:0] cpsr,
    output logic [31:0] spsr,
    output logic        n,
    output logic        z,
    output logic        c,
    output logic        v,
    output logic [4:0]  mode,
    output logic        priv,
    output logic        psr_err
);

    logic [31:0] cpsr_q, cpsr_nxt;
    logic [31:0] spsr_irq_q, spsr_svc_q, spsr_abt_q, spsr_und_q;
`ifdef PSR_FIQ_EN
    logic [31:0] spsr_fiq_q;
`endif
    logic        err_q, err_nxt;

    // One SPSR bank write per cycle, selected by sp_mode.
    logic        sp_we;
    logic [4:0]  sp_mode;
    logic [31:0] sp_data;

    logic [4:0]  cur_mode;
    logic [31:0] spsr_cur;
    logic [3:0]  msr_eff_mask;

    assign cur_mode = cpsr_q[4:0];

    always_comb begin
        spsr_cur = '0;
        case (cur_mode)
`ifdef PSR_FIQ_EN
            MODE_FIQ: spsr_cur = spsr_fiq_q;
`endif
            MODE_IRQ: spsr_cur = spsr_irq_q;
            MODE_SVC: spsr_cur = spsr_svc_q;
            MODE_ABT: spsr_cur = spsr_abt_q;
            MODE_UND: spsr_cur = spsr_und_q;
            default:  spsr_cur = '0;
        endcase
    end

    // User mode may only touch the flags field of the CPSR.
    assign msr_eff_mask = (cur_mode == MODE_USR) ? (msr_mask & 4'b1000) : msr_mask;

    always_comb begin
        cpsr_nxt = cpsr_q;
        sp_we    = 1'b0;
        sp_mode  = cur_mode;
        sp_data  = cpsr_q;
        err_nxt  = 1'b0;

        if (exc_req) begin
            if (mode_has_spsr(exc_mode)) begin
                sp_we            = 1'b1;
                sp_mode          = exc_mode;
                sp_data          = cpsr_q;
                cpsr_nxt[4:0]    = exc_mode;
                cpsr_nxt[CPSR_I] = 1'b1;
                cpsr_nxt[CPSR_T] = 1'b0;
                if (exc_fmask) cpsr_nxt[CPSR_F] = 1'b1;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (exc_ret) begin
            if (!mode_has_spsr(cur_mode) || !mode_valid(spsr_cur[4:0]))
                err_nxt = 1'b1;
            else
                cpsr_nxt = spsr_cur & PSR_MASK;
        end else if (msr_we) begin
            if (msr_spsr) begin
                if (!mode_has_spsr(cur_mode)) begin
                    err_nxt = 1'b1;
                end else begin
                    sp_we   = 1'b1;
                    sp_mode = cur_mode;
                    sp_data = psr_merge(spsr_cur, msr_data, msr_mask);
                end
            end else if (msr_eff_mask[0] && !mode_valid(msr_data[4:0])) begin
                err_nxt = 1'b1;
            end else begin
                cpsr_nxt = psr_merge(cpsr_q, msr_data, msr_eff_mask);
            end
            // The ALU flag write survives when the MSR cannot touch CPSR flags.
            if (flag_we && (msr_spsr || !msr_mask[3]))
                cpsr_nxt[31:28] = {in_n, in_z, in_c, in_v};
        end else if (bx_we) begin
            cpsr_nxt[CPSR_T] = bx_t;
        end else if (flag_we) begin
            cpsr_nxt[31:28] = {in_n, in_z, in_c, in_v};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpsr_q     <= RESET_CPSR & PSR_MASK;
            spsr_irq_q <= SPSR_RESET;
            spsr_svc_q <= SPSR_RESET;
            spsr_abt_q <= SPSR_RESET;
            spsr_und_q <= SPSR_RESET;
`ifdef PSR_FIQ_EN
            spsr_fiq_q <= SPSR_RESET;
`endif
            err_q      <= 1'b0;
        end else begin
            cpsr_q <= cpsr_nxt;
            err_q  <= err_nxt;
            if (sp_we) begin
                case (sp_mode)
`ifdef PSR_FIQ_EN
                    MODE_FIQ: spsr_fiq_q <= sp_data;
`endif
                    MODE_IRQ: spsr_irq_q <= sp_data;
                    MODE_SVC: spsr_svc_q <= sp_data;
                    MODE_ABT: spsr_abt_q <= sp_data;
                    MODE_UND: spsr_und_q <= sp_data;
                    default:  ;
                endcase
            end
        end
    end

    cond_check u_cond (
        .cond      (cond),
        .n         (cpsr_q[CPSR_N]),
        .z         (cpsr_q[CPSR_Z]),
        .c         (cpsr_q[CPSR_C]),
        .v         (cpsr_q[CPSR_V]),
        .cond_pass (cond_pass)
    );

    assign cpsr    = cpsr_q;
    assign spsr    = spsr_cur;
    assign n       = cpsr_q[CPSR_N];
    assign z       = cpsr_q[CPSR_Z];
    assign c       = cpsr_q[CPSR_C];
    assign v       = cpsr_q[CPSR_V];
    assign mode    = cur_mode;
    assign priv    = (cur_mode != MODE_USR);
    assign psr_err = err_q;

endmodule

// File: tb/tb_psr_unit.sv
// tb_psr_unit: directed self-checking bench for psr_unit.
// Inputs are driven 1 time unit after the rising edge; outputs are
// sampled at the same point, well away from the next edge.
module tb_psr_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flag_we, in_n, in_z, in_c, in_v;
    logic        msr_we, msr_spsr;
    logic [3:0]  msr_mask;
    logic [31:0] msr_data;
    logic        bx_we, bx_t;
    logic        exc_req, exc_fmask, exc_ret;
    logic [4:0]  exc_mode;
    logic [3:0]  cond;
    logic        cond_pass;
    logic [31:0] cpsr, spsr;
    logic        n, z, c, v, priv, psr_err;
    logic [4:0]  mode;

    int errors = 0;
    int checks = 0;

    psr_unit dut (
        .clk(clk), .rst_n(rst_n),
        .flag_we(flag_we), .in_n(in_n), .in_z(in_z), .in_c(in_c), .in_v(in_v),
        .msr_we(msr_we), .msr_spsr(msr_spsr), .msr_mask(msr_mask), .msr_data(msr_data),
        .bx_we(bx_we), .bx_t(bx_t),
        .exc_req(exc_req), .exc_mode(exc_mode), .exc_fmask(exc_fmask), .exc_ret(exc_ret),
        .cond(cond), .cond_pass(cond_pass),
        .cpsr(cpsr), .spsr(spsr), .n(n), .z(z), .c(c), .v(v),
        .mode(mode), .priv(priv), .psr_err(psr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        flag_we = 0; {in_n, in_z, in_c, in_v} = 4'b0000;
        msr_we = 0; msr_spsr = 0; msr_mask = 4'b0000; msr_data = '0;
        bx_we = 0; bx_t = 0;
        exc_req = 0; exc_mode = 5'b10000; exc_fmask = 0; exc_ret = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic flags(input logic [3:0] f);
        flag_we = 1; {in_n, in_z, in_c, in_v} = f;
    endtask

    task automatic msr(input logic s, input logic [3:0] m, input logic [31:0] d);
        msr_we = 1; msr_spsr = s; msr_mask = m; msr_data = d;
    endtask

    task automatic exc(input logic [4:0] m, input logic fm);
        exc_req = 1; exc_mode = m; exc_fmask = fm;
    endtask

    // Evaluate all 16 conditions against the stored flags; bit i = cond i.
    task automatic cond_scan(input string tag, input logic [15:0] exp);
        logic [15:0] got;
        got = '0;
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i);
            #1;
            got[i] = cond_pass;
        end
        cond = 4'hE;
        chk(tag, {16'h0, got}, {16'h0, exp});
    endtask

    initial begin
        idle();
        cond  = 4'hE;
        rst_n = 1'b0;
        #12;
        // Reset state
        chk("rst_cpsr", cpsr, 32'h0000_00D3);
        chk("rst_spsr", spsr, 32'h0000_0010);
        chk("rst_err", {31'h0, psr_err}, 32'h0);
        chk("rst_al", {31'h0, cond_pass}, 32'h1);
        cond = 4'h0; #1;
        chk("rst_eq", {31'h0, cond_pass}, 32'h0);
        cond = 4'hE;
        rst_n = 1'b1;
        step();

        // Flag write
        flags(4'b0100); step();
        chk("flag_cpsr", cpsr, 32'h4000_00D3);
        cond = 4'h0; #1; chk("flag_eq", {31'h0, cond_pass}, 32'h1);
        cond = 4'h1; #1; chk("flag_ne", {31'h0, cond_pass}, 32'h0);
        cond = 4'hE;

        // Set up SVC with flags 0110, I/F clear
        msr(0, 4'b1001, 32'h6000_0013); step();
        chk("msr_svc", cpsr, 32'h6000_0013);
        exc(5'b10010, 0); step();
        chk("irq_cpsr", cpsr, 32'h6000_0092);
        chk("irq_spsr", spsr, 32'h6000_0013);
        chk("irq_mode", {27'h0, mode}, 32'h12);
        exc_ret = 1; step();
        chk("ret_cpsr", cpsr, 32'h6000_0013);
        chk("ret_spsr", spsr, 32'h0000_0010);

        // Exception beats flag write; old flags saved
        exc(5'b10111, 0); flags(4'b1001); step();
        chk("abt_cpsr", cpsr, 32'h6000_0097);
        chk("abt_spsr", spsr, 32'h6000_0013);
        exc_ret = 1; flags(4'b1111); step();
        chk("abt_ret", cpsr, 32'h6000_0013);

        // MSR c-field merges with a flag write
        msr(0, 4'b0001, 32'h0000_00D3); flags(4'b1000); step();
        chk("merge", cpsr, 32'h8000_00D3);
        // MSR with f-field: flag write dropped
        msr(0, 4'b1000, 32'h1000_0000); flags(4'b0100); step();
        chk("nomerge", cpsr, 32'h1000_00D3);
        // MSR SPSR merges with flag write to CPSR
        msr(1, 4'b1001, 32'hA000_00D7); flags(4'b1000); step();
        chk("msr_spsr_c", cpsr, 32'h8000_00D3);
        chk("msr_spsr_s", spsr, 32'hA000_00D7);

        // BX beats flag write
        bx_we = 1; bx_t = 1; flags(4'b0100); step();
        chk("bx_t1", cpsr, 32'h8000_00F3);
        bx_we = 1; bx_t = 0; step();
        chk("bx_t0", cpsr, 32'h8000_00D3);

        // Invalid mode in c-field: dropped, one-cycle error pulse
        msr(0, 4'b0001, 32'h0000_00C5); step();
        chk("badm_cpsr", cpsr, 32'h8000_00D3);
        chk("badm_err", {31'h0, psr_err}, 32'h1);
        step();
        chk("badm_err0", {31'h0, psr_err}, 32'h0);

        // Exception to USR is illegal
        exc(5'b10000, 1); step();
        chk("excusr_cpsr", cpsr, 32'h8000_00D3);
        chk("excusr_err", {31'h0, psr_err}, 32'h1);

        // Condition table across flag patterns
        flags(4'b1001); step(); cond_scan("cond_1001", 16'h565A);
        flags(4'b0110); step(); cond_scan("cond_0110", 16'h66A5);
        flags(4'b0010); step(); cond_scan("cond_0010", 16'h55A6);

        // Drop to USR
        msr(0, 4'b0001, 32'h0000_0010); step();
        chk("usr_cpsr", cpsr, 32'h2000_0010);
        chk("usr_priv", {31'h0, priv}, 32'h0);
        chk("usr_spsr", spsr, 32'h0);
        msr(0, 4'b1001, 32'hF000_00D3); step();
        chk("usr_msr", cpsr, 32'hF000_0010);
        chk("usr_msr_err", {31'h0, psr_err}, 32'h0);
        msr(1, 4'b1001, 32'h0000_00D3); step();
        chk("usr_spsr_cpsr", cpsr, 32'hF000_0010);
        chk("usr_spsr_err", {31'h0, psr_err}, 32'h1);
        step();
        chk("usr_spsr_err0", {31'h0, psr_err}, 32'h0);
        exc_ret = 1; step();
        chk("usr_ret_cpsr", cpsr, 32'hF000_0010);
        chk("usr_ret_err", {31'h0, psr_err}, 32'h1);

        // FIQ entry with fmask
        exc(5'b10001, 1); step();
`ifdef PSR_FIQ_EN
        chk("fiq_cpsr", cpsr, 32'hF000_00D1);
        chk("fiq_spsr", spsr, 32'hF000_0010);
        chk("fiq_err", {31'h0, psr_err}, 32'h0);
`else
        chk("fiq_cpsr", cpsr, 32'hF000_0010);
        chk("fiq_err", {31'h0, psr_err}, 32'h1);
`endif

        // Enter UND from here with fmask: F set
        exc(5'b11011, 1); step();
`ifdef PSR_FIQ_EN
        chk("und_cpsr", cpsr, 32'hF000_00DB);
        chk("und_spsr", spsr, 32'hF000_00D1);
`else
        chk("und_cpsr", cpsr, 32'hF000_00DB);
        chk("und_spsr", spsr, 32'hF000_0010);
`endif

        // Asynchronous reset overrides a pending request
        msr(0, 4'b1001, 32'h5000_0013);
        rst_n = 1'b0;
        #1;
        chk("arst_cpsr", cpsr, 32'h0000_00D3);
        chk("arst_spsr", spsr, 32'h0000_0010);
        @(posedge clk); #1;
        chk("arst_hold", cpsr, 32'h0000_00D3);
        idle();
        rst_n = 1'b1;
        step();
        chk("arst_err", {31'h0, psr_err}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
